// File: rtl/rs232_receiver.sv
// ============================================================================
// rs232_receiver : 8N1 UART receiver, mid-bit sampling, 2-flop rx synchroniser
// Optional macro RX_PARITY_EN adds a parity bit (8E1/8O1).       Rev 1.0
// ============================================================================
`default_nettype none

module rs232_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       data_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] c_HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_BIT_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t      r_state, w_state_n;
    logic [1:0]  r_sync;
    logic        w_rx_s;
    logic [15:0] r_cnt, w_cnt_n;
    logic [2:0]  r_idx, w_idx_n;
    logic [7:0]  r_shift, w_shift_n;
    logic        w_done;
`ifdef RX_PARITY_EN
    logic        r_par_bit, w_par_bit_n;
`endif

    assign w_rx_s = r_sync[1];

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_done    = 1'b0;
`ifdef RX_PARITY_EN
        w_par_bit_n = r_par_bit;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_n = S_START;
                    w_cnt_n   = 16'd0;
                end
            end
            S_START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_n = 16'd0;
                    // A start bit that is gone by mid-bit is line noise.
                    if (!w_rx_s) begin
                        w_state_n = S_DATA;
                        w_idx_n   = 3'd0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_BIT_M1) begin
                    w_cnt_n            = 16'd0;
                    w_shift_n[r_idx]   = w_rx_s;
                    w_idx_n            = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == c_BIT_M1) begin
                    w_cnt_n     = 16'd0;
                    w_par_bit_n = w_rx_s;
                    w_state_n   = S_STOP;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == c_BIT_M1) begin
                    w_cnt_n   = 16'd0;
                    w_done    = 1'b1;
                    // Completing at mid-stop lets a zero-gap next start bit be caught.
                    w_state_n = w_rx_s ? S_IDLE : S_BREAK;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync     <= 2'b11;
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_idx      <= 3'd0;
            r_shift    <= 8'd0;
            busy       <= 1'b0;
            data       <= 8'd0;
            valid      <= 1'b0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
            busy    <= (w_state_n != S_IDLE);
            valid   <= w_done;
            if (w_done) begin
                // Completion beats a simultaneous rd; overrun sees pre-edge data_ready.
                data       <= r_shift;
                data_ready <= 1'b1;
                frame_err  <= ~w_rx_s;
                overrun    <= data_ready | (overrun & ~rd);
            end else if (rd) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bit  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            r_par_bit <= w_par_bit_n;
            if (w_done) begin
                parity_err <= (^r_shift) ^ r_par_bit ^ PARITY_ODD;
            end
        end
    end
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
    assign parity_err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rs232_receiver.sv
// Self-checking bench for rs232_receiver: directed scenarios plus randomized
// frames checked against a frame-level reference model.
`default_nettype none

module tb_rs232_receiver;

    localparam int CPB  = 16;
    localparam int H    = CPB / 2;
    localparam bit PODD = 1'b0;
`ifdef RX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int LAT = 2 + H + (FBITS - 1) * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] data;
    logic       valid, data_ready, frame_err, parity_err, overrun, busy;

    int compared   = 0;
    int mismatched = 0;

    rs232_receiver #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd         (rd),
        .data       (data),
        .valid      (valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         vwide = 0;
    int         vcyc = 0;
    logic       prev_v = 1'b0;
    logic [7:0] cap_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            cap_q.push_back(data);
            vcyc = cyc;
            if (prev_v) vwide++;
        end
        prev_v = valid;
    end

    // Frame as sent on the wire: start, 8 data bits LSB first, [parity], stop.
    function automatic logic [10:0] build(input logic [7:0] d, input logic stop, input logic par_ok);
        logic [10:0] f;
        logic        p;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = d;
        p      = (^d) ^ PODD ^ ~par_ok;
`ifdef RX_PARITY_EN
        f[9]  = p;
        f[10] = stop;
`else
        f[9]  = stop;
        f[10] = p | 1'b1;
`endif
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [10:0] f, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            rx = f[c / CPB];
            tick(1);
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        compared++;
        if (data !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_data: got %h want 00", data);
        end
        compared++;
        if ({valid, data_ready, frame_err, parity_err, overrun, busy} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 000000",
                     {valid, data_ready, frame_err, parity_err, overrun, busy});
        end
    endtask

    task automatic test_single();
        int t0;
        cap_q.delete();
        vwide = 0;
        t0 = cyc;
        drive_frame(build(8'hA5, 1'b1, 1'b1), FBITS * CPB);
        rx = 1'b1;
        tick(4);
        compared++;
        if (cap_q.size() != 1) begin
            mismatched++;
            $display("FAIL single_count: got %0d frames want 1", cap_q.size());
        end else begin
            compared++;
            if (cap_q[0] !== 8'hA5) begin
                mismatched++;
                $display("FAIL single_data: got %h want a5", cap_q[0]);
            end
            compared++;
            if ((vcyc - t0) < LAT - 1 || (vcyc - t0) > LAT + 1) begin
                mismatched++;
                $display("FAIL single_latency: got %0d want %0d+-1", vcyc - t0, LAT);
            end
        end
        compared++;
        if (vwide !== 0) begin
            mismatched++;
            $display("FAIL single_valid_width: got %0d extra cycles want 0", vwide);
        end
        compared++;
        if ({data_ready, frame_err, parity_err, busy} !== 4'b1000) begin
            mismatched++;
            $display("FAIL single_flags: got rdy/fe/pe/busy=%b want 1000",
                     {data_ready, frame_err, parity_err, busy});
        end
    endtask

    task automatic test_glitch();
        logic [7:0] d0;
        logic       seen;
        cap_q.delete();
        d0   = data;
        seen = 1'b0;
        for (int c = 0; c < 24; c++) begin
            rx = (c < 4) ? 1'b0 : 1'b1;
            tick(1);
            if (busy) seen = 1'b1;
        end
        compared++;
        if (seen !== 1'b1) begin
            mismatched++;
            $display("FAIL glitch_busy_seen: got %b want 1", seen);
        end
        compared++;
        if (busy !== 1'b0 || cap_q.size() != 0) begin
            mismatched++;
            $display("FAIL glitch_reject: got busy=%b frames=%0d want busy=0 frames=0",
                     busy, cap_q.size());
        end
        compared++;
        if (data !== d0) begin
            mismatched++;
            $display("FAIL glitch_data: got %h want %h", data, d0);
        end
    endtask

    task automatic test_break();
        pulse_rd();
        cap_q.delete();
        drive_frame(build(8'h3C, 1'b0, 1'b1), FBITS * CPB);
        rx = 1'b0;
        tick(40);
        compared++;
        if (cap_q.size() != 1 || data !== 8'h3C) begin
            mismatched++;
            $display("FAIL break_frame: got frames=%0d data=%h want 1 / 3c", cap_q.size(), data);
        end
        compared++;
        if (frame_err !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL break_hold: got fe=%b busy=%b want 1 1", frame_err, busy);
        end
        rx = 1'b1;
        tick(5);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL break_release: got busy=%b want 0", busy);
        end
        tick(2 * FBITS * CPB);
        compared++;
        if (cap_q.size() != 1) begin
            mismatched++;
            $display("FAIL break_no_retrigger: got %0d frames want 1", cap_q.size());
        end
    endtask

    task automatic test_back_to_back();
        pulse_rd();
        tick(1);
        cap_q.delete();
        drive_frame(build(8'h11, 1'b1, 1'b1), FBITS * CPB);
        drive_frame(build(8'h22, 1'b1, 1'b1), FBITS * CPB);
        rx = 1'b1;
        tick(4);
        compared++;
        if (cap_q.size() != 2) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d frames want 2", cap_q.size());
        end else begin
            compared++;
            if (cap_q[0] !== 8'h11 || cap_q[1] !== 8'h22) begin
                mismatched++;
                $display("FAIL b2b_bytes: got %h %h want 11 22", cap_q[0], cap_q[1]);
            end
        end
        compared++;
        if ({data, data_ready, overrun} !== {8'h22, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL b2b_overrun: got data=%h rdy=%b ovr=%b want 22 1 1",
                     data, data_ready, overrun);
        end
        pulse_rd();
        compared++;
        if ({data_ready, overrun} !== 2'b00) begin
            mismatched++;
            $display("FAIL b2b_rd_clear: got rdy=%b ovr=%b want 0 0", data_ready, overrun);
        end
    endtask

    task automatic test_reset_midframe();
        cap_q.delete();
        drive_frame(build(8'($urandom), 1'b1, 1'b1), 4 * CPB + CPB / 2);
        rst = 1'b0;
        #2;
        compared++;
        if ({data, valid, data_ready, frame_err, parity_err, overrun, busy} !== 14'b0) begin
            mismatched++;
            $display("FAIL midreset_async: got data=%h flags=%b want 00 000000", data,
                     {valid, data_ready, frame_err, parity_err, overrun, busy});
        end
        rx = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(FBITS * CPB);
        compared++;
        if (cap_q.size() != 0) begin
            mismatched++;
            $display("FAIL midreset_partial: got %0d frames want 0", cap_q.size());
        end
        drive_frame(build(8'h5A, 1'b1, 1'b1), FBITS * CPB);
        rx = 1'b1;
        tick(4);
        compared++;
        if (cap_q.size() != 1 || data !== 8'h5A || frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_fresh: got frames=%0d data=%h fe=%b want 1 5a 0",
                     cap_q.size(), data, frame_err);
        end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        drive_frame(build(8'h07, 1'b1, 1'b1), FBITS * CPB);
        rx = 1'b1;
        tick(4);
        compared++;
        if (data !== 8'h07 || parity_err !== 1'b0) begin
            mismatched++;
            $display("FAIL parity_good: got data=%h pe=%b want 07 0", data, parity_err);
        end
        drive_frame(build(8'h07, 1'b1, 1'b0), FBITS * CPB);
        rx = 1'b1;
        tick(4);
        compared++;
        if (data !== 8'h07 || parity_err !== 1'b1) begin
            mismatched++;
            $display("FAIL parity_bad: got data=%h pe=%b want 07 1", data, parity_err);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic       m_ready;
        logic       m_ovr;
        logic [7:0] b;
        pulse_rd();
        tick(1);
        cap_q.delete();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        for (int n = 0; n < 24; n++) begin
            rx = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                pulse_rd();
                m_ready = 1'b0;
                m_ovr   = 1'b0;
            end
            tick($urandom_range(0, 3));
            b = 8'($urandom);
            drive_frame(build(b, 1'b1, 1'b1), FBITS * CPB);
            m_ovr   = m_ovr | m_ready;
            m_ready = 1'b1;
            exp_q.push_back(b);
            compared++;
            if ({data, data_ready, overrun, frame_err, parity_err} !== {b, m_ready, m_ovr, 2'b00}) begin
                mismatched++;
                $display("FAIL rand_frame%0d: got data=%h rdy=%b ovr=%b fe=%b pe=%b want %h %b %b 0 0",
                         n, data, data_ready, overrun, frame_err, parity_err, b, m_ready, m_ovr);
            end
        end
        rx = 1'b1;
        tick(4);
        compared++;
        if (cap_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL rand_count: got %0d frames want %0d", cap_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                compared++;
                if (cap_q[i] !== exp_q[i]) begin
                    mismatched++;
                    $display("FAIL rand_stream%0d: got %h want %h", i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        rd  = 1'b0;
        tick(3);
        test_reset();
        rst = 1'b1;
        tick(3);
        test_single();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
